// File: rtl/buffer_word_reader_pkg.sv
// Shared types and constants for the buffer word reader.
//   WORD_W     : width of one buffer word
//   FIFO_DEPTH : entries in the output skid FIFO
//   ENTRY_W    : FIFO entry width (word + last flag)
//   rd_state_t : reader FSM state encoding
package buffer_pkg;

   localparam int WORD_W     = 64;
   localparam int FIFO_DEPTH = 2;
   localparam int ENTRY_W    = WORD_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/buffer_word_reader_if.sv
// Valid/ready word stream from the reader to the compute array.
//   m_valid : word valid            (master -> slave)
//   m_ready : consumer ready        (slave  -> master)
//   m_data  : 64-bit word           (master -> slave)
//   m_last  : final word of command (master -> slave)
interface buffer_word_reader_if;
   import buffer_pkg::*;

   logic              m_valid;
   logic              m_ready;
   logic [WORD_W-1:0] m_data;
   logic              m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/buffer_word_reader_fifo.sv
// skid_fifo2: 2-entry synchronous FIFO holding {last, data}.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : entry to write
//   pop        : drop head this cycle (caller guarantees not empty)
//   count      : current occupancy, 0..2
//   head       : oldest entry; stable until popped
module skid_fifo2
   import buffer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [1:0]         count,
   output logic [ENTRY_W-1:0] head
);

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic               wr_ptr;
   logic               rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         // Simultaneous push and pop leaves the count unchanged.
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/buffer_word_reader.sv
// buffer_word_reader: fetches a contiguous run of 64-bit words from the
// activation/weight buffer (word mode) and streams them out as valid/ready,
// absorbing the 1-cycle buffer latency and backpressure with a 2-entry FIFO.
//   clk, rst_n      : clock, async active-low reset
//   start           : command strobe (accepted only when idle and not busy)
//   base_addr       : first word address
//   length          : word count, 0..BuffDepth/8
//   busy, done      : command in progress / 1-cycle completion pulse
//   buf_*           : buffer word port (read_en, write_en, addr_mode, word_addr, word_out)
//   word_stream     : output stream (master modport)
//   stall_cycles    : only with BUF_READER_STALL_CNT_EN defined; saturating
//                     count of m_valid & !m_ready cycles, cleared on start
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_READ  | issuing buffer reads, throttled by FIFO space
// ST_DRAIN | all reads issued; waiting for the last beat to be taken
module buffer_word_reader
   import buffer_pkg::*;
#(
   parameter int BuffDepth = 256,
   parameter int WordAddrW = $clog2(BuffDepth/8)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WordAddrW-1:0]  base_addr,
   input  logic [WordAddrW:0]    length,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_read_en,
   output logic                  buf_write_en,
   output logic                  buf_addr_mode,
   output logic [WordAddrW-1:0]  buf_word_addr,
   input  logic [WORD_W-1:0]     buf_word_out,
   buffer_word_reader_if.master  word_stream
`ifdef BUF_READER_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   localparam logic [WordAddrW:0]   REM_ONE  = 1;
   localparam logic [WordAddrW-1:0] ADDR_ONE = 1;

   rd_state_t              state_q, state_d;
   logic [WordAddrW:0]     remain_q;
   logic [WordAddrW-1:0]   addr_q;
   logic                   inflight_q;
   logic                   inflight_last_q;
   logic                   done_q;

   logic                   accept;
   logic                   pop;
   logic                   issue_last;
   logic                   drain_empty;
   logic [2:0]             occupancy;
   logic [1:0]             fifo_count;
   logic [ENTRY_W-1:0]     fifo_head;

   // done_q still high means the previous command is in its last busy cycle.
   assign accept      = (state_q == ST_IDLE) && start && !done_q;
   assign pop         = word_stream.m_valid && word_stream.m_ready;
   // Words that will be held next cycle before any new issue.
   assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign buf_read_en = (state_q == ST_READ) && (remain_q != '0) && (occupancy < 3'd2);
   assign issue_last  = buf_read_en && (remain_q == REM_ONE);
   // Only reachable in DRAIN for a zero-length command.
   assign drain_empty = (remain_q == '0) && (fifo_count == 2'd0) && !inflight_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (length == '0) ? ST_DRAIN : ST_READ;
         ST_READ:  if (issue_last) state_d = ST_DRAIN;
         ST_DRAIN: if ((pop && fifo_head[WORD_W]) || drain_empty) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         remain_q        <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         inflight_q      <= buf_read_en;
         inflight_last_q <= issue_last;
         done_q          <= ((state_q == ST_DRAIN) && pop && fifo_head[WORD_W])
                            || (accept && (length == '0));
         if (accept) begin
            remain_q <= length;
            addr_q   <= base_addr;
         end else if (buf_read_en) begin
            remain_q <= remain_q - REM_ONE;
            addr_q   <= addr_q + ADDR_ONE;   // wraps naturally at BuffDepth/8
         end
      end
   end

   skid_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, buf_word_out}),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign busy          = (state_q != ST_IDLE) || done_q;
   assign done          = done_q;
   assign buf_write_en  = 1'b0;
   assign buf_addr_mode = 1'b1;
   assign buf_word_addr = addr_q;

   assign word_stream.m_valid = (fifo_count != 2'd0);
   assign word_stream.m_data  = fifo_head[WORD_W-1:0];
   assign word_stream.m_last  = fifo_head[WORD_W] && (fifo_count != 2'd0);

`ifdef BUF_READER_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (word_stream.m_valid && !word_stream.m_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_buffer_word_reader.sv
module tb_buffer_word_reader;
   import buffer_pkg::*;

   localparam int BUFF_DEPTH = 256;
   localparam int WAW        = 5;
   localparam int NWORDS     = BUFF_DEPTH / 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start;
   logic [WAW-1:0]   base_addr;
   logic [WAW:0]     length;
   logic             busy, done, buf_read_en, buf_write_en, buf_addr_mode;
   logic [WAW-1:0]   buf_word_addr;
   logic [63:0]      buf_word_out = '0;
`ifdef BUF_READER_STALL_CNT_EN
   logic [31:0]      stall_cycles;
`endif

   logic ready_mode = 1'b0;
   logic ready_val  = 1'b1;
   logic ready_rnd  = 1'b1;

   buffer_word_reader_if word_stream();
   assign word_stream.m_ready = ready_mode ? ready_rnd : ready_val;

   always #5 clk = ~clk;

   buffer_word_reader #(.BuffDepth(BUFF_DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .buf_read_en   (buf_read_en),
      .buf_write_en  (buf_write_en),
      .buf_addr_mode (buf_addr_mode),
      .buf_word_addr (buf_word_addr),
      .buf_word_out  (buf_word_out),
      .word_stream   (word_stream)
`ifdef BUF_READER_STALL_CNT_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   // Buffer model: word port with one cycle of read latency.
   logic [63:0] mem [NWORDS];
   always @(posedge clk) if (buf_read_en) buf_word_out <= mem[buf_word_addr];

   always @(posedge clk) ready_rnd <= ($urandom_range(0, 3) != 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      logic        last;
      int          cyc;   // required beat cycle, -1 when not timed
   } beat_t;

   beat_t exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks done, stalls, occupancy.
   int          done_due = -1;
   int          issued = 0;
   int          popped = 0;
   int          beats_seen = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;
   beat_t       e;

   always @(negedge clk) begin
      if (!rst_n) begin
         issued     = 0;
         popped     = 0;
         prev_stall = 1'b0;
      end else begin
         if (word_stream.m_valid && !word_stream.m_ready) begin
            chk("occupancy_le_2", 64'((issued - popped) <= 2), 64'd1);
            if (prev_stall) begin
               chk("stall_data_stable", word_stream.m_data, prev_data);
               chk("stall_last_stable", 64'(word_stream.m_last), 64'(prev_last));
            end
            prev_stall = 1'b1;
            prev_data  = word_stream.m_data;
            prev_last  = word_stream.m_last;
         end else begin
            prev_stall = 1'b0;
         end
         if (word_stream.m_valid && word_stream.m_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got data %0h, required no beat (cycle %0d)",
                        word_stream.m_data, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", word_stream.m_data, e.data);
               chk("beat_last", 64'(word_stream.m_last), 64'(e.last));
               chk("port_mode", 64'({buf_write_en, buf_addr_mode}), 64'd1);
               if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
               if (e.last) done_due = cyc + 1;
            end
            beats_seen++;
            popped++;
         end
         if (done || (done_due == cyc)) chk("done_pulse", 64'(done), 64'(done_due == cyc));
         if (buf_read_en) issued++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit && (busy || done); i++) step();
      chk("idle_reached", 64'(busy || done), 64'd0);
   endtask

   task automatic wait_beats(input int target, input int limit);
      for (int i = 0; i < limit && beats_seen < target; i++) step();
      chk("beats_reached", 64'(beats_seen >= target), 64'd1);
   endtask

   // Drive a start in the current cycle and queue the words it must produce.
   task automatic issue(input int base, input int len, input bit timed);
      int t;
      beat_t b;
      t         = cyc;
      start     = 1'b1;
      base_addr = WAW'(base);
      length    = (WAW+1)'(len);
      for (int i = 0; i < len; i++) begin
         b.data = mem[(base + i) % NWORDS];
         b.last = (i == len - 1);
         b.cyc  = timed ? t + 3 + i : -1;
         exp_q.push_back(b);
      end
      if (len == 0) done_due = t + 1;
      step();
      start = 1'b0;
   endtask

   task automatic run(input int base, input int len, input bit timed);
      wait_idle(200);
      issue(base, len, timed);
      wait_idle(400);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int n0;
      int b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      for (int i = 0; i < NWORDS; i++) mem[i] = 64'h1111_1111_1111_1111 * 64'(i);

      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_done",   64'(done), 64'd0);
      chk("rst_rd_en",  64'(buf_read_en), 64'd0);
      chk("rst_valid",  64'(word_stream.m_valid), 64'd0);
      chk("rst_last",   64'(word_stream.m_last), 64'd0);
      chk("rst_data",   word_stream.m_data, 64'd0);
      chk("rst_addr",   64'(buf_word_addr), 64'd0);
      chk("rst_mode",   64'({buf_write_en, buf_addr_mode}), 64'd1);
      rst_n = 1'b1;
      step();

      // Basic run: beats at T+3..T+6, done at T+7.
      run(2, 4, 1'b1);
      // Address wrap 30, 31, 0, 1.
      run(30, 4, 1'b1);

      // Backpressure: 5 cycles of m_ready = 0 mid-stream.
      wait_idle(200);
      b0 = beats_seen;
      issue(5, 8, 1'b0);
      wait_beats(b0 + 3, 50);
      ready_val = 1'b0;
      repeat (5) step();
      ready_val = 1'b1;
      wait_idle(200);

      // Zero length, with a start during the busy cycle that must be ignored.
      wait_idle(200);
      n0 = issued;
      issue(0, 0, 1'b0);
      chk("len0_busy_t1", 64'(busy), 64'd1);
      start     = 1'b1;
      base_addr = 5'd3;
      length    = 6'd3;
      step();
      start = 1'b0;
      chk("len0_busy_t2", 64'(busy), 64'd0);
      repeat (6) step();
      chk("len0_no_reads", 64'(issued), 64'(n0));

      // Reset mid-command at beat 2 of 6.
      wait_idle(200);
      b0 = beats_seen;
      issue(10, 6, 1'b0);
      wait_beats(b0 + 2, 50);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  64'(busy), 64'd0);
      chk("arst_done",  64'(done), 64'd0);
      chk("arst_rd_en", 64'(buf_read_en), 64'd0);
      chk("arst_valid", 64'(word_stream.m_valid), 64'd0);
      chk("arst_last",  64'(word_stream.m_last), 64'd0);
      chk("arst_data",  word_stream.m_data, 64'd0);
      chk("arst_addr",  64'(buf_word_addr), 64'd0);
      exp_q.delete();
      done_due = -1;
      step();
      step();
      rst_n = 1'b1;
      repeat (4) begin
         step();
         chk("arst_no_done", 64'(done), 64'd0);
      end
      run(0, 5, 1'b1);

      // Randomized commands with random backpressure.
      for (int i = 0; i < NWORDS; i++) mem[i] = {$urandom, $urandom};
      ready_mode = 1'b1;
      repeat (12) run($urandom_range(0, NWORDS - 1), $urandom_range(1, 12), 1'b0);
      run(7, NWORDS, 1'b0);
      ready_mode = 1'b0;
      ready_val  = 1'b1;

`ifdef BUF_READER_STALL_CNT_EN
      wait_idle(200);
      ready_val = 1'b0;
      issue(1, 4, 1'b0);
      for (int i = 0; i < 20 && !word_stream.m_valid; i++) step();
      repeat (3) step();
      ready_val = 1'b1;
      wait_idle(200);
      chk("stall_count", 64'(stall_cycles), 64'd3);
      issue(0, 2, 1'b0);
      chk("stall_clear", 64'(stall_cycles), 64'd0);
      wait_idle(200);
`endif

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/buffer_word_reader.md
# buffer_word_reader

Read-side engine for the 64-bit activation/weight buffer. On a start command it fetches a contiguous run of 64-bit words through the buffer's word port (`addr_mode = 1`) and presents them as a valid/ready stream to the compute array. It absorbs the buffer's 1-cycle read latency and downstream backpressure with a 2-entry skid FIFO, so it sustains one word per cycle.

## Interface
- `BuffDepth`, 256: buffer size in bytes; must be a power of two and at least 16.
- `WordAddrW`, `$clog2(BuffDepth/8)`: word address width.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  WordAddrW  first word address; captured when `start` is accepted.
- `length`  in  WordAddrW+1  number of words, 0 to BuffDepth/8; captured when `start` is accepted.
- `busy`  out  1  a command is in progress.
- `done`  out  1  1-cycle pulse when a command completes.
- `buf_read_en`  out  1  to buffer `read_en`.
- `buf_write_en`  out  1  to buffer `write_en`; constant 0.
- `buf_addr_mode`  out  1  to buffer `addr_mode`; constant 1 (word mode).
- `buf_word_addr`  out  WordAddrW  to buffer `word_addr`.
- `buf_word_out`  in  64  from buffer `word_out`; valid in the cycle after `buf_read_en`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  64  stream word.
- `m_last`  out  1  marks the final word of the command.

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE to READ when `start` = 1 and `length` != 0.
  - IDLE to DRAIN when `start` = 1 and `length` = 0. There are no reads and no beats; `done` is asserted in the next cycle.
  - READ to DRAIN in the cycle the final read is issued.
  - DRAIN to IDLE on the handshake of the `m_last` beat, or immediately for `length` = 0.
- `start` is ignored while `busy` = 1.
- Issue rule: `buf_read_en` = 1 when all of the following hold:
  - the state is READ;
  - words remaining to issue > 0;
  - `fifo_count + inflight − pop < 2`, where `pop` = `m_valid & m_ready` in the current cycle.
- Address generation: `buf_word_addr` starts at `base_addr`. It increments by 1 after each issued read and wraps modulo BuffDepth/8, so address BuffDepth/8−1 is followed by 0.
- `inflight` = registered `buf_read_en`. When `inflight` = 1, `buf_word_out` is pushed into the FIFO in that cycle.
- Stream output is FIFO head: `m_valid` = (`fifo_count` != 0).
- `m_last` = 1 on the beat whose word index equals `length` − 1.
- `m_data` and `m_last` hold stable while `m_valid` = 1 and `m_ready` = 0.
- `done` = 1 for exactly one cycle, the cycle after the `m_last` handshake.
- `busy` = 1 from the cycle after `start` is accepted through the `done` cycle inclusive.
- Reset values: `busy`, `done`, `buf_read_en`, `m_valid` and `m_last` are 0; `m_data`, `buf_word_addr` and the FIFO count are 0; the state is IDLE.
- Reset asserted mid-command aborts it. The FIFO and in-flight data are discarded, and no `done` pulse is produced.

## Timing
- `start` accepted in cycle T:
  - first `buf_read_en` in T+1;
  - data on `buf_word_out` in T+2, pushed into the FIFO at the end of T+2;
  - first `m_valid` in T+3.
- With `m_ready` held at 1, throughput is 1 word/cycle. The last beat is in T+2+N and `done` is in T+3+N.
- With `m_ready` = 0, at most 2 words are buffered; no read is issued that would overflow the FIFO.
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- The earliest a new `start` can be accepted is the cycle after `done`.

## Configuration
- `BUF_READER_STALL_CNT_EN`:
  - Defined: adds output `stall_cycles` [31:0]. It increments in every cycle with `m_valid & !m_ready`, saturates at 0xFFFFFFFF, clears on an accepted `start`, and resets to 0.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `buffer_pkg`:
  - FSM state typedef (IDLE/READ/DRAIN);
  - `WORD_W` = 64;
  - `FIFO_DEPTH` = 2.
- One sub-module, `skid_fifo2`: a 2-entry, 65-bit (data + last) synchronous FIFO with `push`, `pop`, `count`, head outputs and asynchronous active-low reset.

## Test plan
- Preload words 0..7 with value = 0x1111_1111_1111_1111 × index. Send `start` with `base_addr` = 2, `length` = 4 and `m_ready` = 1. Required response:
  - beats with index multipliers 2, 3, 4, 5 in T+3..T+6;
  - `m_last` on the 4th beat;
  - `done` in T+7.
- Wrap case, BuffDepth = 256 (32 words): `base_addr` = 30, `length` = 4. Required response: addresses 30, 31, 0, 1 are read and the stream data matches.
- Backpressure: hold `m_ready` = 0 for 5 cycles mid-stream. Required response:
  - no more than 2 words are buffered;
  - `m_data` is stable throughout;
  - no word is lost or duplicated after release.
- `length` = 0. Required response: `busy` lasts 1 cycle, `done` pulses, there is no `buf_read_en` and no `m_valid`. A `start` while `busy` = 1 is ignored.
- Assert `rst_n` = 0 mid-command at beat 2 of 6. Required response:
  - all outputs return to their reset values asynchronously;
  - no `done` pulse;
  - a new command afterwards works normally.
- With `BUF_READER_STALL_CNT_EN` defined: 3 stall cycles give `stall_cycles` = 3, and the next accepted `start` clears it to 0.
